// File: rtl/pipe_stage_chain_if.sv
// rtl/pipe_stage_chain_if.sv - handshake and bundle signals for the pipeline stage chain
interface pipe_stage_chain_if #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 16,
    parameter int DEPTH  = 2
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic              FLUSH;
    logic              IN_VALID;
    logic              IN_READY;
    logic [DATA_W-1:0] IN_DATA;
    logic [CTRL_W-1:0] IN_CTRL;
    logic              OUT_VALID;
    logic              OUT_READY;
    logic [DATA_W-1:0] OUT_DATA;
    logic [CTRL_W-1:0] OUT_CTRL;
    logic [OCC_W-1:0]  OCCUPANCY;

    // Upstream/downstream side that drives bundles in and consumes them
    modport master (
        output FLUSH, IN_VALID, IN_DATA, IN_CTRL, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_DATA, OUT_CTRL, OCCUPANCY
    );

    // The chain itself
    modport slave (
        input  FLUSH, IN_VALID, IN_DATA, IN_CTRL, OUT_READY,
        output IN_READY, OUT_VALID, OUT_DATA, OUT_CTRL, OCCUPANCY
    );
endinterface

// File: rtl/pipe_stage_chain.sv
// rtl/pipe_stage_chain.sv - DEPTH-stage valid/ready register chain with bubble collapse and flush
module pipe_stage_chain #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 16,
    parameter int DEPTH  = 2
) (
    input  logic               CLK,
    input  logic               RESET,
    pipe_stage_chain_if.slave  bus
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  v_q, v_d;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [CTRL_W-1:0] ctrl_q [DEPTH];
    logic [CTRL_W-1:0] ctrl_d [DEPTH];
    logic [OCC_W-1:0]  occ_q, occ_d;

    logic [DEPTH-1:0]  take;
    logic [DEPTH-1:0]  src_v;
    logic [DATA_W-1:0] src_data [DEPTH];
    logic [CTRL_W-1:0] src_ctrl [DEPTH];
    logic              in_rdy;
    logic              in_xfer;
    logic              out_xfer;

    // A stage advances if it is empty or the stage after it advances; empty stages always load
    always_comb begin
        take            = '0;
        take[DEPTH-1]   = !v_q[DEPTH-1] | bus.OUT_READY;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            take[i] = !v_q[i] | take[i+1];
        end
    end

    // Each stage's source: stage 0 from the input port, the rest from the previous stage
    always_comb begin
        src_v       = '0;
        src_v[0]    = bus.IN_VALID;
        src_data[0] = bus.IN_DATA;
        src_ctrl[0] = bus.IN_CTRL;
        for (int i = 1; i < DEPTH; i++) begin
            src_v[i]    = v_q[i-1];
            src_data[i] = data_q[i-1];
            src_ctrl[i] = ctrl_q[i-1];
        end
    end

    assign in_rdy   = take[0] & ~bus.FLUSH;
    assign in_xfer  = bus.IN_VALID & in_rdy;
    assign out_xfer = v_q[DEPTH-1] & bus.OUT_READY;

    // Next-state: flush clears valids and ctrl (data holds), otherwise advancing stages load
    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        ctrl_d = ctrl_q;
        occ_d  = occ_q;
        if (bus.FLUSH) begin
            v_d   = '0;
            occ_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                ctrl_d[i] = '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (take[i]) begin
                    v_d[i]    = src_v[i];
                    data_d[i] = src_data[i];
                    ctrl_d[i] = src_v[i] ? src_ctrl[i] : '0;
                end
            end
            occ_d = occ_q + OCC_W'(in_xfer) - OCC_W'(out_xfer);
        end
    end

    // State registers with asynchronous clear of every field
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            v_q   <= '0;
            occ_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                ctrl_q[i] <= '0;
            end
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
            ctrl_q <= ctrl_d;
            occ_q  <= occ_d;
        end
    end

    assign bus.IN_READY  = in_rdy;
    assign bus.OUT_VALID = v_q[DEPTH-1];
    assign bus.OUT_DATA  = data_q[DEPTH-1];
    assign bus.OUT_CTRL  = ctrl_q[DEPTH-1];
    assign bus.OCCUPANCY = occ_q;
endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb/tb_pipe_stage_chain.sv - scoreboard bench for pipe_stage_chain at DEPTH 3
module tb_pipe_stage_chain;
    localparam int DATA_W = 32;
    localparam int CTRL_W = 4;
    localparam int DEPTH  = 3;

    logic CLK;
    logic RESET;
    int   tests;
    int   fails;
    logic [35:0] sb[$];

    pipe_stage_chain_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .DEPTH(DEPTH)) bus ();

    pipe_stage_chain #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .DEPTH(DEPTH)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Drive one cycle just after the rising edge; at the falling edge check acceptance and queue the expected bundle
    task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] c,
                         input logic ordy, input logic fl, input logic exp_rdy);
        @(posedge CLK);
        #1;
        bus.IN_VALID  = v;
        bus.IN_DATA   = d;
        bus.IN_CTRL   = c;
        bus.OUT_READY = ordy;
        bus.FLUSH     = fl;
        @(negedge CLK);
        if (v) begin
            chk("in_ready", 64'(bus.IN_READY), 64'(exp_rdy));
            if (exp_rdy) sb.push_back({d, c});
        end
    endtask

    task automatic drain(input int n);
        repeat (n) drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1);
        chk("drained_occ", 64'(bus.OCCUPANCY), 64'd0);
        chk("drained_valid", 64'(bus.OUT_VALID), 64'd0);
        chk("drained_sb", 64'(sb.size()), 64'd0);
    endtask

    // Output monitor: pops the scoreboard on every output transfer, and watches ctrl while invalid
    always @(negedge CLK) begin
        if (RESET) begin
            if (!bus.OUT_VALID) chk("ctrl_idle", 64'(bus.OUT_CTRL), 64'd0);
            if (bus.OUT_VALID && bus.OUT_READY) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL out_unexpected: got 0x%0h required no transfer", bus.OUT_DATA);
                end else begin
                    logic [35:0] exp;
                    exp = sb.pop_front();
                    chk("out_bundle", 64'({bus.OUT_DATA, bus.OUT_CTRL}), 64'(exp));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        RESET = 1'b0;
        bus.FLUSH     = 1'b0;
        bus.IN_VALID  = 1'b0;
        bus.IN_DATA   = '0;
        bus.IN_CTRL   = '0;
        bus.OUT_READY = 1'b1;
        #2;
        chk("rst_valid", 64'(bus.OUT_VALID), 64'd0);
        chk("rst_data", 64'(bus.OUT_DATA), 64'd0);
        chk("rst_ctrl", 64'(bus.OUT_CTRL), 64'd0);
        chk("rst_occ", 64'(bus.OCCUPANCY), 64'd0);
        chk("rst_in_ready", 64'(bus.IN_READY), 64'd1);
        @(negedge CLK);
        RESET = 1'b1;

        // Streaming with OUT_READY held high
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h10 + i, 4'hA, 1'b1, 1'b0, 1'b1);
            chk("stream_valid", 64'(bus.OUT_VALID), (i == 3) ? 64'd1 : 64'd0);
            chk("stream_occ", 64'(bus.OCCUPANCY), 64'(i));
        end
        drain(5);

        // Backpressure: three accepted, then refused until released
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h20 + i, 4'h3, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'h23, 4'h3, 1'b0, 1'b0, 1'b0);
        chk("bp_occ", 64'(bus.OCCUPANCY), 64'd3);
        chk("bp_data", 64'(bus.OUT_DATA), 64'h20);
        drive(1'b1, 32'h23, 4'h3, 1'b0, 1'b0, 1'b0);
        chk("bp_data_hold", 64'(bus.OUT_DATA), 64'h20);
        chk("bp_valid_hold", 64'(bus.OUT_VALID), 64'd1);
        drive(1'b1, 32'h23, 4'h3, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 32'h24, 4'h3, 1'b1, 1'b0, 1'b1);
        chk("bp_release_occ", 64'(bus.OCCUPANCY), 64'd3);
        drain(5);

        // Bubble collapse: A, gap, B, then stall once A is at the output
        drive(1'b1, 32'h30, 4'h5, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 32'h31, 4'h6, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        chk("bub_a_out", 64'(bus.OUT_DATA), 64'h30);
        chk("bub_occ", 64'(bus.OCCUPANCY), 64'd2);
        drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        chk("bub_occ_hold", 64'(bus.OCCUPANCY), 64'd2);
        chk("bub_in_ready", 64'(bus.IN_READY), 64'd1);
        drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1);
        chk("bub_b_next", 64'(bus.OUT_DATA), 64'h31);
        chk("bub_b_valid", 64'(bus.OUT_VALID), 64'd1);
        drain(4);

        // Flush with a full chain and a simultaneous offer
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h40 + i, 4'h7, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'h43, 4'h7, 1'b0, 1'b1, 1'b0);
        sb.delete();
        drive(1'b1, 32'h44, 4'h9, 1'b1, 1'b0, 1'b1);
        chk("fl_valid", 64'(bus.OUT_VALID), 64'd0);
        chk("fl_ctrl", 64'(bus.OUT_CTRL), 64'd0);
        chk("fl_occ", 64'(bus.OCCUPANCY), 64'd0);
        drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1);
        chk("fl_lat1", 64'(bus.OUT_VALID), 64'd0);
        drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1);
        chk("fl_lat2", 64'(bus.OUT_VALID), 64'd0);
        drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1);
        chk("fl_lat3_valid", 64'(bus.OUT_VALID), 64'd1);
        chk("fl_lat3_data", 64'(bus.OUT_DATA), 64'h44);
        drain(3);

        // Asynchronous reset between edges with two bundles in flight
        drive(1'b1, 32'h50, 4'hC, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'h51, 4'hC, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        chk("ar_pre_data", 64'(bus.OUT_DATA), 64'h50);
        chk("ar_pre_ctrl", 64'(bus.OUT_CTRL), 64'hC);
        chk("ar_pre_occ", 64'(bus.OCCUPANCY), 64'd2);
        #2;
        RESET = 1'b0;
        #1;
        chk("ar_valid", 64'(bus.OUT_VALID), 64'd0);
        chk("ar_data", 64'(bus.OUT_DATA), 64'd0);
        chk("ar_ctrl", 64'(bus.OUT_CTRL), 64'd0);
        chk("ar_occ", 64'(bus.OCCUPANCY), 64'd0);
        chk("ar_in_ready", 64'(bus.IN_READY), 64'd1);
        sb.delete();
        #1;
        RESET = 1'b1;
        drain(2);

        // Full chain with simultaneous input and output
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h60 + i, 4'h1, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'h55, 4'h2, 1'b1, 1'b0, 1'b1);
        chk("fs_occ", 64'(bus.OCCUPANCY), 64'd3);
        chk("fs_out0", 64'(bus.OUT_DATA), 64'h60);
        drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1);
        chk("fs_occ_same", 64'(bus.OCCUPANCY), 64'd3);
        chk("fs_out1", 64'(bus.OUT_DATA), 64'h61);
        drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1);
        chk("fs_occ2", 64'(bus.OCCUPANCY), 64'd2);
        chk("fs_out2", 64'(bus.OUT_DATA), 64'h62);
        drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1);
        chk("fs_55_data", 64'(bus.OUT_DATA), 64'h55);
        chk("fs_55_ctrl", 64'(bus.OUT_CTRL), 64'h2);
        chk("fs_occ1", 64'(bus.OCCUPANCY), 64'd1);
        drain(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
